// File: rtl/irig_pkg.sv
// Shared IRIG decode definitions: symbol codes, tolerance percentages, frame length and FSM states.
package irig_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;
  localparam logic [1:0] SYM_ERR  = 2'b11;

  localparam int PCT_ZMIN = 10;
  localparam int PCT_Z1   = 35;
  localparam int PCT_M1   = 65;
  localparam int PCT_MMAX = 95;

  localparam int FRAME_BITS = 100;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_HIGH,
    ST_LOW
  } irig_state_e;

  function automatic logic [1:0] classify(input int w, input int zmin, input int z1,
                                          input int m1, input int mmax);
    if (w >= zmin && w < z1) return SYM_ZERO;
    if (w >= z1 && w < m1) return SYM_ONE;
    if (w >= m1 && w <= mmax) return SYM_MARK;
    return SYM_ERR;
  endfunction

endpackage

// File: rtl/irig_input_filter.sv
// 2-flop synchroniser for the raw IRIG pin; 2 clk latency, or 2+FILT_LEN with IRIG_GLITCH_FILTER_EN.
// With IRIG_GLITCH_FILTER_EN the level only follows after FILT_LEN consecutive equal samples.
module irig_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irigb,
  output logic lvl
);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("irig_input_filter: FILT_LEN must be at least 1");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = irigb;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef IRIG_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the current output; any agreeing sample restarts.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == FW'(FILT_LEN - 1)) filt_d = sync2_q;
      else                            cnt_d  = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

endmodule

// File: rtl/irig_width_decode_param.sv
// IRIG pulse-width decoder: ZERO/ONE/MARK/ERR classification, frame reference tracking, loss-of-signal.
// Symbol strobes 1 clk after the synchronised fall; optional IRIG_GLITCH_FILTER_EN debounce on the input.
module irig_width_decode_param
  import irig_pkg::*;
#(
  parameter int CLK_HZ       = 10000000,
  parameter int BIT_RATE_HZ  = 100,
  parameter int TIMEOUT_BITS = 2,
  parameter int FILT_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irigb,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic       irig_d0,
  output logic       irig_d1,
  output logic       irig_mark,
  output logic       sym_err,
  output logic       frame_start,
  output logic [6:0] bit_idx,
  output logic       frame_locked,
  output logic       signal_ok
);

  localparam int P      = CLK_HZ / BIT_RATE_HZ;
  localparam int TO_CYC = TIMEOUT_BITS * P;
  localparam int CW     = $clog2(TO_CYC + 1);
  localparam int ZMIN   = P * PCT_ZMIN / 100;
  localparam int Z1     = P * PCT_Z1 / 100;
  localparam int M1     = P * PCT_M1 / 100;
  localparam int MMAX   = P * PCT_MMAX / 100;

  logic          lvl;
  logic          lvl_dly_q, lvl_dly_d;
  logic          rise, fall, timeout, emit;
  logic [1:0]    code;
  irig_state_e   state_q, state_d;
  logic [CW-1:0] width_q, width_d;
  logic [CW-1:0] int_cnt_q, int_cnt_d;
  logic          prev_mark_q, prev_mark_d;
  logic          sym_valid_q, sym_valid_d;
  logic [1:0]    sym_code_q, sym_code_d;
  logic          d0_q, d0_d, d1_q, d1_d, mark_q, mark_d;
  logic          sym_err_q, sym_err_d;
  logic          frame_start_q, frame_start_d;
  logic [6:0]    bit_idx_q, bit_idx_d;
  logic          locked_q, locked_d;
  logic          sig_ok_q, sig_ok_d;

  irig_input_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .irigb(irigb),
    .lvl  (lvl)
  );

  assign rise = lvl & ~lvl_dly_q;
  assign fall = ~lvl & lvl_dly_q;
  // A rising edge on the expiry cycle restarts the interval instead of declaring loss.
  assign timeout = ~rise && (int_cnt_q == CW'(TO_CYC - 1));
  assign emit    = (state_q == ST_HIGH) && fall && ~timeout;
  assign code    = classify(int'(width_q), ZMIN, Z1, M1, MMAX);

  always_comb begin
    lvl_dly_d     = lvl;
    state_d       = state_q;
    width_d       = width_q;
    int_cnt_d     = int_cnt_q;
    prev_mark_d   = prev_mark_q;
    sym_valid_d   = 1'b0;
    sym_code_d    = sym_code_q;
    d0_d          = 1'b0;
    d1_d          = 1'b0;
    mark_d        = 1'b0;
    sym_err_d     = 1'b0;
    frame_start_d = 1'b0;
    bit_idx_d     = bit_idx_q;
    locked_d      = locked_q;
    sig_ok_d      = sig_ok_q;

    if (rise)                              int_cnt_d = '0;
    else if (int_cnt_q != CW'(TO_CYC))     int_cnt_d = int_cnt_q + CW'(1);

    case (state_q)
      ST_HIGH: begin
        if (fall)                          state_d = ST_LOW;
        else if (width_q != {CW{1'b1}})    width_d = width_q + CW'(1);
      end
      default: begin
        if (rise) begin
          state_d = ST_HIGH;
          width_d = CW'(1);
        end
      end
    endcase

    if (rise) sig_ok_d = 1'b1;

    if (emit) begin
      sym_valid_d = 1'b1;
      sym_code_d  = code;
      d0_d        = (code == SYM_ZERO);
      d1_d        = (code == SYM_ONE);
      mark_d      = (code == SYM_MARK);
      if (code == SYM_ERR) begin
        sym_err_d = 1'b1;
        locked_d  = 1'b0;
      end else if (code == SYM_MARK && prev_mark_q) begin
        frame_start_d = 1'b1;
        bit_idx_d     = '0;
        locked_d      = 1'b1;
      end else begin
        bit_idx_d   = (bit_idx_q == 7'(FRAME_BITS - 1)) ? 7'd0 : bit_idx_q + 7'd1;
        prev_mark_d = (code == SYM_MARK);
      end
    end

    if (timeout) begin
      state_d     = ST_SEARCH;
      sig_ok_d    = 1'b0;
      locked_d    = 1'b0;
      prev_mark_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_dly_q     <= 1'b0;
      state_q       <= ST_SEARCH;
      width_q       <= '0;
      int_cnt_q     <= '0;
      prev_mark_q   <= 1'b0;
      sym_valid_q   <= 1'b0;
      sym_code_q    <= SYM_ZERO;
      d0_q          <= 1'b0;
      d1_q          <= 1'b0;
      mark_q        <= 1'b0;
      sym_err_q     <= 1'b0;
      frame_start_q <= 1'b0;
      bit_idx_q     <= '0;
      locked_q      <= 1'b0;
      sig_ok_q      <= 1'b0;
    end else begin
      lvl_dly_q     <= lvl_dly_d;
      state_q       <= state_d;
      width_q       <= width_d;
      int_cnt_q     <= int_cnt_d;
      prev_mark_q   <= prev_mark_d;
      sym_valid_q   <= sym_valid_d;
      sym_code_q    <= sym_code_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      mark_q        <= mark_d;
      sym_err_q     <= sym_err_d;
      frame_start_q <= frame_start_d;
      bit_idx_q     <= bit_idx_d;
      locked_q      <= locked_d;
      sig_ok_q      <= sig_ok_d;
    end
  end

  assign sym_valid    = sym_valid_q;
  assign sym_code     = sym_code_q;
  assign irig_d0      = d0_q;
  assign irig_d1      = d1_q;
  assign irig_mark    = mark_q;
  assign sym_err      = sym_err_q;
  assign frame_start  = frame_start_q;
  assign bit_idx      = bit_idx_q;
  assign frame_locked = locked_q;
  assign signal_ok    = sig_ok_q;

endmodule

// File: tb/tb_irig_width_decode_param.sv
// Bench for irig_width_decode_param at P=100 cycles per bit; model works from pulse widths and frame rules.
module tb_irig_width_decode_param;

  localparam int CLK_HZ       = 10000;
  localparam int BIT_RATE_HZ  = 100;
  localparam int TIMEOUT_BITS = 2;
  localparam int FILT_LEN     = 4;
  localparam int P            = CLK_HZ / BIT_RATE_HZ;
`ifdef IRIG_GLITCH_FILTER_EN
  localparam int LAT   = 3 + FILT_LEN;
  localparam int MIN_W = FILT_LEN;
`else
  localparam int LAT   = 3;
  localparam int MIN_W = 1;
`endif

  logic       clk, rst_n, irigb;
  logic       sym_valid, irig_d0, irig_d1, irig_mark, sym_err, frame_start;
  logic       frame_locked, signal_ok;
  logic [1:0] sym_code;
  logic [6:0] bit_idx;

  irig_width_decode_param #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE_HZ (BIT_RATE_HZ),
    .TIMEOUT_BITS(TIMEOUT_BITS),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irigb       (irigb),
    .sym_valid   (sym_valid),
    .sym_code    (sym_code),
    .irig_d0     (irig_d0),
    .irig_d1     (irig_d1),
    .irig_mark   (irig_mark),
    .sym_err     (sym_err),
    .frame_start (frame_start),
    .bit_idx     (bit_idx),
    .frame_locked(frame_locked),
    .signal_ok   (signal_ok)
  );

  typedef struct {
    int         cyc;
    logic [1:0] code;
    logic       vld, err, d0, d1, mk, fs, lk, ok;
    logic [6:0] idx;
  } ev_t;

  ev_t  evq[$];
  ev_t  mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_rise = 0;
  int   w;
  logic m_prev = 1'b0;
  int   m_idx = 0;
  logic m_lk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is logged so that missing, extra or misaligned symbols all show up.
  always @(negedge clk) begin
    if (sym_valid || sym_err || frame_start || irig_d0 || irig_d1 || irig_mark) begin
      mon_e.cyc  = cyc;
      mon_e.code = sym_code;
      mon_e.vld  = sym_valid;
      mon_e.err  = sym_err;
      mon_e.d0   = irig_d0;
      mon_e.d1   = irig_d1;
      mon_e.mk   = irig_mark;
      mon_e.fs   = frame_start;
      mon_e.lk   = frame_locked;
      mon_e.ok   = signal_ok;
      mon_e.idx  = bit_idx;
      evq.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Symbol windows as percentages of the bit period: ZERO, ONE, MARK (upper bound inclusive for MARK).
  function automatic int ref_code(input int width);
    int lo_pct[3] = '{10, 35, 65};
    int hi_pct[3] = '{35, 65, 95};
    for (int k = 0; k < 3; k++) begin
      if (width * 100 >= lo_pct[k] * P && (width * 100 < hi_pct[k] * P ||
          (k == 2 && width * 100 <= hi_pct[k] * P)))
        return k;
    end
    return 3;
  endfunction

  function automatic int rand_w(input int cls);
    case (cls)
      0:       return $urandom_range(P * 35 / 100 - 1, P * 10 / 100);
      1:       return $urandom_range(P * 65 / 100 - 1, P * 35 / 100);
      default: return $urandom_range(P * 95 / 100, P * 65 / 100);
    endcase
  endfunction

  function automatic int gap_for(input int width);
    return (P - width < 10) ? 10 : P - width;
  endfunction

  task automatic expect_sym(input int width, input int fall_c);
    int   code;
    logic fs;
    ev_t  e;
    if (width < MIN_W) begin
      check("glitch_no_sym", evq.size(), 0);
      evq.delete();
      return;
    end
    code = ref_code(width);
    fs   = 1'b0;
    if (code == 3) begin
      m_lk = 1'b0;
    end else if (code == 2 && m_prev) begin
      fs    = 1'b1;
      m_idx = 0;
      m_lk  = 1'b1;
    end else begin
      m_idx  = (m_idx + 1) % 100;
      m_prev = (code == 2);
    end
    check("sym_count", evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check("sym_cycle", e.cyc, fall_c + LAT);
      check("sym_valid", e.vld, 1);
      check("sym_code", e.code, code);
      check("legacy_strobes", {e.d0, e.d1, e.mk}, {code == 0, code == 1, code == 2});
      check("sym_err", e.err, code == 3);
      check("frame_start", e.fs, fs);
      check("bit_idx", e.idx, m_idx);
      check("frame_locked", e.lk, m_lk);
      check("signal_ok_sym", e.ok, 1);
    end
    evq.delete();
  endtask

  task automatic pulse(input int width, input int lo);
    int fall_c;
    irigb     = 1'b1;
    last_rise = cyc;
    repeat (width) @(negedge clk);
    irigb  = 1'b0;
    fall_c = cyc;
    repeat (lo) @(negedge clk);
    expect_sym(width, fall_c);
  endtask

  initial begin
    int bnd[8] = '{9, 10, 34, 35, 64, 65, 95, 96};
    rst_n = 1'b0;
    irigb = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_code", sym_code, 0);
    check("rst_d0", irig_d0, 0);
    check("rst_d1", irig_d1, 0);
    check("rst_mark", irig_mark, 0);
    check("rst_sym_err", sym_err, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_locked", frame_locked, 0);
    check("rst_signal_ok", signal_ok, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_signal_ok", signal_ok, 0);

    pulse(20, 80);
    pulse(50, 50);
    pulse(80, 20);
    foreach (bnd[i]) pulse(bnd[i], gap_for(bnd[i]));

    for (int f = 0; f < 2; f++) begin
      w = rand_w(2); pulse(w, gap_for(w));
      w = rand_w(2); pulse(w, gap_for(w));
      for (int b = 0; b < 98; b++) begin
        w = rand_w($urandom_range(1, 0));
        pulse(w, gap_for(w));
      end
    end

    pulse(20, 30);
    repeat (last_rise + 198 - cyc) @(negedge clk);
    check("sig_ok_before_to", signal_ok, 1);
    check("locked_before_to", frame_locked, 1);
    repeat (12) @(negedge clk);
    check("sig_ok_after_to", signal_ok, 0);
    check("locked_after_to", frame_locked, 0);
    check("to_no_sym", evq.size(), 0);
    m_lk   = 1'b0;
    m_prev = 1'b0;
    pulse(50, 50);

    pulse(50, 40);
    pulse(3, 40);
    pulse(20, 80);

    for (int r = 0; r < 40; r++) begin
      w = $urandom_range(100, 1);
      pulse(w, $urandom_range(40, 10));
    end

    irigb = 1'b1;
    repeat (40) @(negedge clk);
    check("pre_rst_signal_ok", signal_ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_signal_ok", signal_ok, 0);
    check("mid_rst_bit_idx", bit_idx, 0);
    check("mid_rst_sym_valid", sym_valid, 0);
    check("mid_rst_locked", frame_locked, 0);
    @(negedge clk);
    repeat (40) @(negedge clk);
    irigb = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_sym", evq.size(), 0);
    check("post_rst_signal_ok", signal_ok, 0);
    evq.delete();
    m_prev = 1'b0;
    m_idx  = 0;
    m_lk   = 1'b0;
    pulse(80, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
